// File: rtl/minmax_scan.sv
// Stream-scan unit: accepts one frame of signed samples and reports the signed
// minimum and maximum with the index of the first occurrence of each.
module minmax_scan #(
  parameter int DW = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] min_val,
  output logic [DW-1:0] max_val,
  output logic [LW-1:0] min_idx,
  output logic [LW-1:0] max_idx,
  output logic [1:0]    state_dbg
);

  // Handshake: a sample is consumed on every rising edge where in_valid and
  // in_ready are both high; in_ready is high only while scanning and does not
  // depend on in_valid. in_valid may drop at any time and simply stalls the scan.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [DW-1:0] min_val_q, min_val_d;
  logic [DW-1:0] max_val_q, max_val_d;
  logic [LW-1:0] min_idx_q, min_idx_d;
  logic [LW-1:0] max_idx_q, max_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          beat;

  // Overflow-safe signed a < b: differing signs decide directly, otherwise the
  // difference cannot overflow and its sign bit is the answer.
  function automatic logic slt(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] diff;
    diff = a - b;
    slt  = (a[DW-1] != b[DW-1]) ? a[DW-1] : diff[DW-1];
  endfunction

  assign beat = in_valid && busy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    min_val_d = min_val_q;
    max_val_d = max_val_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            err_d = 1'b1;
          end else begin
            len_d   = len;
            cnt_d   = '0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        // abort beats a simultaneous sample: it is consumed but never compared
        if (abort) begin
          state_d = IDLE;
        end else if (beat) begin
          cnt_d = cnt_q + LW'(1);
          if (cnt_q == '0) begin
            min_val_d = in_data;
            max_val_d = in_data;
            min_idx_d = '0;
            max_idx_d = '0;
          end else begin
            if (slt(in_data, min_val_q)) begin
              min_val_d = in_data;
              min_idx_d = cnt_q;
            end
            if (slt(max_val_q, in_data)) begin
              max_val_d = in_data;
              max_idx_d = cnt_q;
            end
          end
          if (cnt_q == len_q - LW'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      min_val_q <= '0;
      max_val_q <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      min_val_q <= min_val_d;
      max_val_q <= max_val_d;
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign min_val   = min_val_q;
  assign max_val   = max_val_q;
  assign min_idx   = min_idx_q;
  assign max_idx   = max_idx_q;
  assign state_dbg = state_q;

endmodule
